sha3_pad_stream: RTL and testbench

AXI-Stream padder placed directly upstream of the Keccak state loader. It accepts a byte-granular message stream and applies SHA-3 multi-rate padding: domain suffix 0x06 and final bit 0x80. It emits whole rate blocks as DATA_WIDTH words for the selected digest mode. The output stream drives the loader's TVALID/TLAST/TID/TUSER/data inputs:

- TLAST marks the last word of every rate block.
- TID marks the last word of the final (padded) block.

---
 rtl/sha3_pad_stream.sv | 157 +++++++++++++++
 tb/tb_sha3_pad_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_pad_stream.sv
// SHA-3 multi-rate padder: turns a byte-granular AXI-Stream message into whole
// rate blocks (suffix 0x06, final bit 0x80) for the Keccak state loader.
module sha3_pad_stream #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    s_TVALID,
   output logic                    s_TREADY,
   input  logic [DATA_WIDTH-1:0]   s_TDATA,
   input  logic [DATA_WIDTH/8-1:0] s_TKEEP,
   input  logic                    s_TLAST,
   input  logic [1:0]              s_TUSER,
   output logic                    m_TVALID,
   input  logic                    m_TREADY,
   output logic [DATA_WIDTH-1:0]   m_TDATA,
   output logic                    m_TLAST,
   output logic                    m_TID,
   output logic [1:0]              m_TUSER
);

   localparam int unsigned BPW = DATA_WIDTH / 8;
   localparam int unsigned CW  = 8;

   localparam logic ST_MSG = 1'b0;
   localparam logic ST_PAD = 1'b1;

   logic                  state_q, state_d;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic                  sp_q, sp_d;
   logic                  first_q, first_d;
   logic [1:0]            mode_q, mode_d;
   logic                  run_q;

   logic                  valid_d, last_d, id_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic [1:0]            user_d;

   logic [1:0]            cur_mode;
   logic [CW-1:0]         last_w;
   logic                  blk_end;
   logic                  ld;
   logic                  accept;
   logic [CW-1:0]         kcnt;
   logic [DATA_WIDTH-1:0] part_word;

   // Next-state, next-output and handshake logic
   always_comb begin
      cur_mode = first_q ? s_TUSER : mode_q;
      case (cur_mode)
         2'd0:    last_w = CW'(144 / BPW - 1);
         2'd1:    last_w = CW'(136 / BPW - 1);
         2'd2:    last_w = CW'(104 / BPW - 1);
         default: last_w = CW'(72 / BPW - 1);
      endcase
      blk_end  = (wcnt_q == last_w);
      ld       = !m_TVALID || m_TREADY;
      s_TREADY = run_q && (state_q == ST_MSG) && ld;
      accept   = s_TVALID && s_TREADY;

      // Keep mask is contiguous from bit 0, so the suffix byte sits at popcount
      kcnt = '0;
      for (int unsigned i = 0; i < BPW; i++) begin
         kcnt = kcnt + CW'(s_TKEEP[i]);
      end
      for (int unsigned i = 0; i < BPW; i++) begin
         part_word[8*i +: 8] = s_TKEEP[i] ? s_TDATA[8*i +: 8]
                             : ((CW'(i) == kcnt) ? 8'h06 : 8'h00);
      end

      state_d = state_q;
      wcnt_d  = wcnt_q;
      sp_d    = sp_q;
      first_d = first_q;
      mode_d  = mode_q;
      valid_d = ld ? 1'b0 : m_TVALID;
      data_d  = m_TDATA;
      last_d  = m_TLAST;
      id_d    = m_TID;
      user_d  = m_TUSER;

      if (state_q == ST_MSG) begin
         if (accept) begin
            valid_d = 1'b1;
            user_d  = cur_mode;
            mode_d  = cur_mode;
            first_d = 1'b0;
            wcnt_d  = blk_end ? '0 : wcnt_q + CW'(1);
            data_d  = s_TDATA;
            last_d  = blk_end;
            id_d    = 1'b0;
            if (s_TLAST) begin
               if (&s_TKEEP) begin
                  state_d = ST_PAD;
                  sp_d    = 1'b1;
               end else begin
                  data_d = part_word;
                  if (blk_end) begin
                     data_d[DATA_WIDTH-1 -: 8] = data_d[DATA_WIDTH-1 -: 8] | 8'h80;
                     id_d    = 1'b1;
                     first_d = 1'b1;
                  end else begin
                     state_d = ST_PAD;
                     sp_d    = 1'b0;
                  end
               end
            end
         end
      end else if (ld) begin
         valid_d = 1'b1;
         user_d  = mode_q;
         data_d  = '0;
         if (sp_q) begin
            data_d[7:0] = 8'h06;
            sp_d        = 1'b0;
         end
         last_d = blk_end;
         id_d   = blk_end;
         wcnt_d = blk_end ? '0 : wcnt_q + CW'(1);
         if (blk_end) begin
            data_d[DATA_WIDTH-1 -: 8] = data_d[DATA_WIDTH-1 -: 8] | 8'h80;
            state_d = ST_MSG;
            first_d = 1'b1;
         end
      end
   end

   // State and output register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q  <= ST_MSG;
         wcnt_q   <= '0;
         sp_q     <= 1'b0;
         first_q  <= 1'b1;
         mode_q   <= '0;
         run_q    <= 1'b0;
         m_TVALID <= 1'b0;
         m_TDATA  <= '0;
         m_TLAST  <= 1'b0;
         m_TID    <= 1'b0;
         m_TUSER  <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         sp_q     <= sp_d;
         first_q  <= first_d;
         mode_q   <= mode_d;
         run_q    <= 1'b1;
         m_TVALID <= valid_d;
         m_TDATA  <= data_d;
         m_TLAST  <= last_d;
         m_TID    <= id_d;
         m_TUSER  <= user_d;
      end
   end

endmodule

// File: tb/tb_sha3_pad_stream.sv
// Directed bench for sha3_pad_stream at DATA_WIDTH=64 with hand-computed padded blocks.
module tb_sha3_pad_stream;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        s_TVALID, s_TREADY, s_TLAST;
   logic [63:0] s_TDATA;
   logic [7:0]  s_TKEEP;
   logic [1:0]  s_TUSER;
   logic        m_TVALID, m_TREADY, m_TLAST, m_TID;
   logic [63:0] m_TDATA;
   logic [1:0]  m_TUSER;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] d;
      logic        l;
      logic        id;
      logic [1:0]  u;
   } rec_t;

   rec_t        q[$];
   logic [63:0] ed  [0:31];
   logic        el  [0:31];
   logic        eid [0:31];
   logic        bp_done;

   localparam logic [63:0] TOP = 64'h8000000000000000;

   sha3_pad_stream #(.DATA_WIDTH(64)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_TVALID(s_TVALID), .s_TREADY(s_TREADY), .s_TDATA(s_TDATA),
      .s_TKEEP(s_TKEEP), .s_TLAST(s_TLAST), .s_TUSER(s_TUSER),
      .m_TVALID(m_TVALID), .m_TREADY(m_TREADY), .m_TDATA(m_TDATA),
      .m_TLAST(m_TLAST), .m_TID(m_TID), .m_TUSER(m_TUSER)
   );

   always #5 ACLK = ~ACLK;

   // Inputs change at posedge+1, so the negedge sees the values for the next edge
   always @(negedge ACLK) begin
      rec_t r;
      if (ARESETn && m_TVALID && m_TREADY) begin
         r.d = m_TDATA; r.l = m_TLAST; r.id = m_TID; r.u = m_TUSER;
         q.push_back(r);
      end
   end

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                            input logic l, input logic [1:0] u);
      int n = 0;
      s_TVALID = 1'b1; s_TDATA = d; s_TKEEP = k; s_TLAST = l; s_TUSER = u;
      do begin
         @(negedge ACLK);
         n++;
      end while (!s_TREADY && n < 500);
      if (!s_TREADY) begin
         checks++; errors++;
         $display("FAIL beat_accept: s_TREADY stayed %b, required 1 within 500 cycles", s_TREADY);
      end
      @(posedge ACLK); #1;
      s_TVALID = 1'b0; s_TLAST = 1'b0;
   endtask

   task automatic wait_words(input int n);
      int c = 0;
      while (q.size() < n && c < 2000) begin
         @(negedge ACLK);
         c++;
      end
      repeat (20) @(negedge ACLK);
      @(posedge ACLK); #1;
   endtask

   task automatic clear_exp(input int n);
      for (int i = 0; i < 32; i++) begin
         ed[i] = '0; el[i] = 1'b0; eid[i] = 1'b0;
      end
      ed[n-1] = TOP; el[n-1] = 1'b1; eid[n-1] = 1'b1;
   endtask

   task automatic test_reset;
      ARESETn = 1'b0; s_TVALID = 1'b0; s_TDATA = '0; s_TKEEP = '0;
      s_TLAST = 1'b0; s_TUSER = '0; m_TREADY = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
      checks++; if (m_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_TVALID); end
      checks++; if (m_TDATA !== 64'd0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_TDATA); end
      checks++; if (m_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_TLAST); end
      checks++; if (m_TID !== 1'b0) begin errors++; $display("FAIL reset_tid: got %b want 0", m_TID); end
      checks++; if (m_TUSER !== 2'd0) begin errors++; $display("FAIL reset_tuser: got %0d want 0", m_TUSER); end
      checks++; if (s_TREADY !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_TREADY); end
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
   endtask

   task automatic test_empty;
      q.delete();
      clear_exp(9);
      ed[0] = 64'h06;
      send_beat(64'hDEADBEEFDEADBEEF, 8'h00, 1'b1, 2'd3);
      wait_words(9);
      checks++; if (q.size() !== 9) begin errors++; $display("FAIL empty_count: got %0d want 9", q.size()); end
      for (int i = 0; i < 9 && i < q.size(); i++) begin
         checks++;
         if (q[i].d !== ed[i] || q[i].l !== el[i] || q[i].id !== eid[i] || q[i].u !== 2'd3) begin
            errors++;
            $display("FAIL empty_w%0d: got %h l%b id%b u%0d want %h l%b id%b u3",
                     i, q[i].d, q[i].l, q[i].id, q[i].u, ed[i], el[i], eid[i]);
         end
      end
   endtask

   task automatic test_abc;
      q.delete();
      clear_exp(17);
      ed[0] = 64'h0000000006636261;
      send_beat(64'h0000000000636261, 8'h07, 1'b1, 2'd1);
      wait_words(17);
      checks++; if (q.size() !== 17) begin errors++; $display("FAIL abc_count: got %0d want 17", q.size()); end
      for (int i = 0; i < 17 && i < q.size(); i++) begin
         checks++;
         if (q[i].d !== ed[i] || q[i].l !== el[i] || q[i].id !== eid[i] || q[i].u !== 2'd1) begin
            errors++;
            $display("FAIL abc_w%0d: got %h l%b id%b u%0d want %h l%b id%b u1",
                     i, q[i].d, q[i].l, q[i].id, q[i].u, ed[i], el[i], eid[i]);
         end
      end
   endtask

   task automatic test_exact_fill;
      q.delete();
      clear_exp(18);
      for (int i = 0; i < 9; i++) ed[i] = {8{8'(i + 1)}};
      el[8] = 1'b1;
      ed[9] = 64'h06;
      // Mode changes on later beats must be ignored
      for (int i = 0; i < 9; i++) send_beat({8{8'(i + 1)}}, 8'hFF, (i == 8), (i == 0) ? 2'd3 : 2'd0);
      wait_words(18);
      checks++; if (q.size() !== 18) begin errors++; $display("FAIL fill_count: got %0d want 18", q.size()); end
      for (int i = 0; i < 18 && i < q.size(); i++) begin
         checks++;
         if (q[i].d !== ed[i] || q[i].l !== el[i] || q[i].id !== eid[i] || q[i].u !== 2'd3) begin
            errors++;
            $display("FAIL fill_w%0d: got %h l%b id%b u%0d want %h l%b id%b u3",
                     i, q[i].d, q[i].l, q[i].id, q[i].u, ed[i], el[i], eid[i]);
         end
      end
   endtask

   task automatic test_top_slot;
      q.delete();
      clear_exp(9);
      for (int i = 0; i < 8; i++) ed[i] = {8{8'hA0 + 8'(i)}};
      ed[8] = 64'h8611111111111111;
      for (int i = 0; i < 8; i++) send_beat({8{8'hA0 + 8'(i)}}, 8'hFF, 1'b0, 2'd3);
      send_beat(64'hFF11111111111111, 8'h7F, 1'b1, 2'd3);
      wait_words(9);
      checks++; if (q.size() !== 9) begin errors++; $display("FAIL top_count: got %0d want 9", q.size()); end
      for (int i = 0; i < 9 && i < q.size(); i++) begin
         checks++;
         if (q[i].d !== ed[i] || q[i].l !== el[i] || q[i].id !== eid[i] || q[i].u !== 2'd3) begin
            errors++;
            $display("FAIL top_w%0d: got %h l%b id%b u%0d want %h l%b id%b u3",
                     i, q[i].d, q[i].l, q[i].id, q[i].u, ed[i], el[i], eid[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      int bad = 0;
      q.delete();
      clear_exp(13);
      ed[0] = 64'h0807060504030201;
      ed[1] = 64'h100F0E0D0C0B0A09;
      ed[2] = 64'h0000000614131211;
      bp_done = 1'b0;
      fork
         begin
            send_beat(64'h0807060504030201, 8'hFF, 1'b0, 2'd2);
            send_beat(64'h100F0E0D0C0B0A09, 8'hFF, 1'b0, 2'd0);
            send_beat(64'hAAAAAAAA14131211, 8'h0F, 1'b1, 2'd1);
         end
         begin
            int c = 0;
            while (!bp_done && c < 3000) begin
               @(posedge ACLK); #1;
               m_TREADY = 1'($urandom_range(0, 1));
               c++;
            end
            m_TREADY = 1'b1;
         end
         begin
            int c = 0;
            logic stall = 1'b0;
            rec_t prev;
            while (q.size() < 13 && c < 3000) begin
               @(negedge ACLK);
               c++;
               if (stall && (m_TVALID !== 1'b1 || m_TDATA !== prev.d || m_TLAST !== prev.l ||
                             m_TID !== prev.id || m_TUSER !== prev.u)) bad++;
               if (m_TVALID && !m_TREADY && s_TREADY) bad++;
               stall   = m_TVALID && !m_TREADY;
               prev.d  = m_TDATA; prev.l = m_TLAST; prev.id = m_TID; prev.u = m_TUSER;
            end
            bp_done = 1'b1;
         end
      join
      m_TREADY = 1'b1;
      wait_words(13);
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall: got %0d stall violations want 0", bad); end
      checks++; if (q.size() !== 13) begin errors++; $display("FAIL bp_count: got %0d want 13", q.size()); end
      for (int i = 0; i < 13 && i < q.size(); i++) begin
         checks++;
         if (q[i].d !== ed[i] || q[i].l !== el[i] || q[i].id !== eid[i] || q[i].u !== 2'd2) begin
            errors++;
            $display("FAIL bp_w%0d: got %h l%b id%b u%0d want %h l%b id%b u2",
                     i, q[i].d, q[i].l, q[i].id, q[i].u, ed[i], el[i], eid[i]);
         end
      end
   endtask

   task automatic test_reset_mid_pad;
      int c = 0;
      q.delete();
      send_beat(64'h0000000000636261, 8'h07, 1'b1, 2'd1);
      while (q.size() < 3 && c < 200) begin
         @(negedge ACLK);
         c++;
      end
      @(posedge ACLK); #1;
      ARESETn = 1'b0;
      #1;
      checks++; if (m_TVALID !== 1'b0) begin errors++; $display("FAIL rstpad_tvalid: got %b want 0", m_TVALID); end
      checks++; if (s_TREADY !== 1'b0) begin errors++; $display("FAIL rstpad_tready: got %b want 0", s_TREADY); end
      repeat (3) @(posedge ACLK);
      #1;
      q.delete();
      ARESETn = 1'b1;
      clear_exp(18);
      ed[0] = 64'h06;
      send_beat(64'h0, 8'h00, 1'b1, 2'd0);
      wait_words(18);
      checks++; if (q.size() !== 18) begin errors++; $display("FAIL rstpad_count: got %0d want 18", q.size()); end
      for (int i = 0; i < 18 && i < q.size(); i++) begin
         checks++;
         if (q[i].d !== ed[i] || q[i].l !== el[i] || q[i].id !== eid[i] || q[i].u !== 2'd0) begin
            errors++;
            $display("FAIL rstpad_w%0d: got %h l%b id%b u%0d want %h l%b id%b u0",
                     i, q[i].d, q[i].l, q[i].id, q[i].u, ed[i], el[i], eid[i]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_empty;
      test_abc;
      test_exact_fill;
      test_top_slot;
      test_backpressure;
      test_reset_mid_pad;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
